// File: rtl/lc3b_types.sv
// lc3b_types: shared lc3b types, including the cache-line and line-arbiter definitions
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_c_line;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D} lc3b_arb_state;
  typedef enum logic {CLIENT_I, CLIENT_D} lc3b_arb_client;
  function automatic lc3b_arb_client arb_pick(input logic i_req, input logic d_req,
                                              input lc3b_arb_client last, input logic rr);
    return (d_req && !(i_req && rr && last == CLIENT_D)) ? CLIENT_D : CLIENT_I;
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes I/D line requests onto one L2 port; MEM_ARBITER_RR_EN selects round-robin over fixed D priority
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);
`ifdef MEM_ARBITER_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif
  lc3b_arb_state state, state_n;
  lc3b_arb_client rr_last, pick;
  logic d_req, grant, done;
  assign d_req = d_read | d_write;
  assign pick = arb_pick(i_read, d_req, rr_last, RR_EN);
  assign grant = (state == ARB_IDLE) && (i_read || d_req);
  assign done = i_resp | d_resp;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;
  // state register; reset abandons any open transaction
  always_ff @(posedge clk)
    state <= rst ? ARB_IDLE : state_n;
  // response demux to the grant owner and next-state selection
  always_comb begin
    i_resp = (state == ARB_GRANT_I) && l2_resp;
    d_resp = (state == ARB_GRANT_D) && l2_resp;
    state_n = grant ? ((pick == CLIENT_D) ? ARB_GRANT_D : ARB_GRANT_I) : done ? ARB_IDLE : state;
  end
  // L2 request bank: loaded from the winner on grant, strobes dropped on completion
  always_ff @(posedge clk)
    if (rst) begin
      l2_read <= 1'b0;
      l2_write <= 1'b0;
      l2_address <= '0;
      l2_wdata <= '0;
      rr_last <= CLIENT_I;
    end else if (grant) begin
      rr_last <= pick;
      l2_address <= (pick == CLIENT_D) ? d_address : i_address;
      l2_read <= (pick == CLIENT_D) ? ~d_write : 1'b1;
      l2_write <= (pick == CLIENT_D) && d_write;
      l2_wdata <= (pick == CLIENT_D) ? d_wdata : l2_wdata;
    end else if (done) begin
      l2_read <= 1'b0;
      l2_write <= 1'b0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and randomized traffic against a grant-order model
module tb_mem_arbiter;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] i_address = '0, d_address = '0, l2_address;
  logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, l2_resp = 1'b0;
  logic [127:0] d_wdata = '0, l2_rdata = '0, i_rdata, d_rdata, l2_wdata;
  logic i_resp, d_resp, l2_read, l2_write;
  int n_cmp = 0, n_bad = 0;
  bit last_d;
  typedef struct {
    logic i_rd, d_rd, d_wr;
    logic [15:0] ia, da;
    logic [127:0] wd;
    logic exp_d;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_address(l2_address), .l2_read(l2_read), .l2_write(l2_write), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always @(posedge clk)
    if (!rst) assert (!(d_read && d_write)) else $error("illegal d_read and d_write together");

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Entered on the negedge after the grant edge; returns on the negedge after completion.
  task automatic serve(input bit w, input int lat, input logic [127:0] rd, input bit jig, input string tag);
    logic [15:0] a;
    logic wr;
    logic [127:0] wd;
    a = w ? d_address : i_address;
    wr = w & d_write;
    wd = d_wdata;
    for (int c = 0; c <= lat; c++) begin
      chk({tag, " l2_read"}, 128'(l2_read), 128'(!wr));
      chk({tag, " l2_write"}, 128'(l2_write), 128'(wr));
      chk({tag, " l2_address"}, 128'(l2_address), 128'(a));
      if (wr) chk({tag, " l2_wdata"}, l2_wdata, wd);
      chk({tag, " early resp"}, 128'(i_resp | d_resp), 128'(0));
      if (c < lat) begin
        @(negedge clk);
        if (w) begin d_address = 16'($urandom); d_wdata = rnd_line(); end
        else i_address = 16'($urandom);
        if (jig) begin i_read = 1'($urandom); i_address = 16'($urandom); end
        #1;
      end
    end
    if (jig) i_read = 1'b0;
    l2_resp = 1'b1;
    l2_rdata = rd;
    #1;
    chk({tag, " i_resp"}, 128'(i_resp), 128'(!w));
    chk({tag, " d_resp"}, 128'(d_resp), 128'(w));
    chk({tag, " owner rdata"}, w ? d_rdata : i_rdata, rd);
    chk({tag, " other rdata"}, w ? i_rdata : d_rdata, rd);
    @(negedge clk);
    l2_resp = 1'b0;
    if (w) begin d_read = 1'b0; d_write = 1'b0; end
    else i_read = 1'b0;
    #1;
    chk({tag, " strobes after resp"}, 128'(l2_read | l2_write), 128'(0));
    chk({tag, " resp after done"}, 128'(i_resp | d_resp), 128'(0));
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, {8{16'h1234}}, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0FFF, 16'h0000, '0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, '0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0002, 16'h0001, '0, RR ? 1'b0 : 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h8000, 16'h7FFE, {4{32'h0F0F_55AA}}, RR ? 1'b0 : 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, '0, 1'b0};

    // reset held with a pending I read, then the lone I read completes
    @(negedge clk);
    i_read = 1'b1;
    i_address = 16'h1230;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset l2_read", 128'(l2_read), 128'(0));
      chk("reset resp", 128'(i_resp | d_resp), 128'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    serve(1'b0, 4, {16{8'hA5}}, 1'b0, "lone_i");

    // D write held stable while I toggles
    d_write = 1'b1;
    d_address = 16'h4000;
    d_wdata = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    serve(1'b1, 3, '0, 1'b1, "d_write");

    // directed vectors; a losing request is served after one idle cycle
    for (int k = 0; k < 6; k++) begin
      i_read = vecs[k].i_rd; d_read = vecs[k].d_rd; d_write = vecs[k].d_wr;
      i_address = vecs[k].ia; d_address = vecs[k].da; d_wdata = vecs[k].wd;
      @(negedge clk);
      serve(vecs[k].exp_d, k % 3, {4{32'h5A5A_0000 ^ 32'(k)}}, 1'b0, $sformatf("vec%0d", k));
      if (vecs[k].i_rd && (vecs[k].d_rd || vecs[k].d_wr)) begin
        @(negedge clk);
        serve(!vecs[k].exp_d, 1, ~{4{32'(k)}}, 1'b0, $sformatf("vec%0d second", k));
      end
    end

    // back-to-back D reads with I pending
    reset_dut();
    i_read = 1'b1; i_address = 16'h0100;
    d_read = 1'b1; d_address = 16'h0200;
    for (int k = 0; k < 3; k++) begin
      bit w;
      w = RR ? (k != 1) : 1'b1;
      @(negedge clk);
      serve(w, 0, rnd_line(), 1'b0, $sformatf("b2b%0d", k));
      if (w && k < 2) d_read = 1'b1;
    end
    if (!RR) begin
      @(negedge clk);
      serve(1'b0, 0, rnd_line(), 1'b0, "b2b i");
    end

    // spurious l2_resp in IDLE, then reset in the middle of a D grant
    @(negedge clk);
    l2_resp = 1'b1;
    #1;
    chk("spurious resp", 128'(i_resp | d_resp), 128'(0));
    @(negedge clk);
    l2_resp = 1'b0;
    chk("spurious strobes", 128'(l2_read | l2_write), 128'(0));
    d_read = 1'b1;
    d_address = 16'h2222;
    @(negedge clk);
    chk("pre-reset grant", 128'(l2_read), 128'(1));
    rst = 1'b1;
    d_read = 1'b0;
    @(negedge clk);
    chk("reset drops strobe", 128'(l2_read), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    l2_resp = 1'b1;
    #1;
    chk("late resp ignored", 128'(i_resp | d_resp), 128'(0));
    @(negedge clk);
    l2_resp = 1'b0;
    #1;
    chk("stays idle", 128'(l2_read | l2_write), 128'(0));

    // random traffic against the grant-order model
    reset_dut();
    last_d = 1'b0;
    for (int t = 0; t < 150; t++) begin
      bit dp, w;
      if (!i_read && $urandom % 2 == 0) begin i_read = 1'b1; i_address = 16'($urandom); end
      if (!d_read && !d_write && $urandom % 2 == 0) begin
        if ($urandom % 2 == 0) d_write = 1'b1; else d_read = 1'b1;
        d_address = 16'($urandom);
        d_wdata = rnd_line();
      end
      if (!i_read && !d_read && !d_write) begin i_read = 1'b1; i_address = 16'($urandom); end
      dp = d_read | d_write;
      w = (dp && i_read) ? (RR ? !last_d : 1'b1) : dp;
      @(negedge clk);
      serve(w, int'($urandom_range(0, 4)), rnd_line(), 1'b0, $sformatf("rand%0d", t));
      last_d = w;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
